// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU-side master and the mem_responder slave.
interface mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering one request at a time after WAIT_CYCLES wait states.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses are suppressed and flagged via rsp_err.
module mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [Depth];

  logic                enter_resp;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_be;
  logic [1:0]          acc_off;
  logic                misaligned;
  logic                mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    off_d      = off_q;
    enter_resp = 1'b0;
    acc_we     = we_q;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    acc_be     = be_q;
    acc_off    = off_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[ADDR_W+1:2];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          off_d   = bus.req_addr[1:0];
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the accept edge is also the access edge, so use live fields.
            state_d    = StResp;
            enter_resp = 1'b1;
            acc_we     = bus.req_we;
            acc_idx    = bus.req_addr[ADDR_W+1:2];
            acc_wdata  = bus.req_wdata;
            acc_be     = bus.req_be;
            acc_off    = bus.req_addr[1:0];
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (acc_off != 2'b00);
`else
    misaligned = 1'b0;
`endif

    // Reset wins over the access on the same edge.
    mem_we  = enter_resp && acc_we && !misaligned && !rst;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (enter_resp) begin
      rdata_d = (acc_we || misaligned) ? 32'h0 : mem_q[acc_idx];
      err_d   = misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    off_q   <= off_d;
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign bus.rsp_err = err_q;
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
`else
  assign bus.rsp_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+2], acc_off, err_q};
`endif

endmodule
